// File: rtl/sysid_checker_pkg.sv
// ---------------------------------------------------------------------------
// sysid_checker_pkg
// Shared types and constants for the boot-time system-ID checker.
//   CheckerState  : sequencer states (IDLE .. DONE)
//   FC_*          : result codes reported on fail_code
//   RETRY_W       : width of the full-sequence retry counter
//   counterWidth(): bit width needed for a watchdog that counts to a limit
// ---------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK,
        DONE
    } CheckerState;

    localparam logic [1:0] FC_OK      = 2'd0;
    localparam logic [1:0] FC_ID      = 2'd1;
    localparam logic [1:0] FC_TS      = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    // Retry limit can be as large as 15, so four bits always suffice.
    localparam int RETRY_W = 4;

    // Smallest width that can hold the value timeoutCycles itself, because
    // the watchdog compares against the limit rather than limit-1.
    function automatic int counterWidth(input int timeoutCycles);
        return (timeoutCycles < 2) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/sysid_watchdog.sv
// ---------------------------------------------------------------------------
// sysid_watchdog
// Per-read timeout counter. Counts up while enabled, stops at the limit and
// flags expiry. A clear takes priority over counting so the sequencer can
// restart the window on the same edge it enters a new request.
//   clock, reset : system clock, asynchronous active-high reset
//   i_clear      : synchronous return to zero
//   i_enable     : count this cycle
//   o_expired    : count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module sysid_watchdog
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                 COUNT_W = counterWidth(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] LIMIT   = COUNT_W'(TIMEOUT_CYCLES);

    logic [COUNT_W-1:0] r_count;
    logic               w_atLimit;

    assign w_atLimit = (r_count == LIMIT);
    assign o_expired = w_atLimit;

    // Saturating counter: holding at the limit keeps the expired flag stable
    // and prevents a wrap back to zero if the sequencer lingers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_atLimit) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
// Boot-time controller that reads the two-word system-ID slave (word 0 =
// system ID, word 1 = build timestamp), compares both against expected values
// and reports the verdict to the boot sequencer.
//   clock, reset        : system clock, asynchronous active-high reset
//   start               : one-cycle pulse that launches a check sequence
//   busy / done         : sequence running / result available
//   pass, fail_code     : verdict, valid while done (0 ok, 1 ID, 2 TS, 3 timeout)
//   avm_*               : Avalon-MM read master toward the sysid slave
//   id_word, timestamp_word : last captured words, for a status register
// ---------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1346454016,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_word,
    output logic [31:0] timestamp_word
);

    CheckerState        r_state;
    logic [RETRY_W-1:0] r_retryCount;

    logic w_inReqWait;
    logic w_inWait;
    logic w_dataWins;
    logic w_expired;
    logic w_timeout;
    logic w_canRetry;
    logic w_wdClear;

    // The watchdog covers the whole request+wait window of one word, so it
    // runs in all four bus states and is cleared whenever a REQ state is
    // about to be entered (fresh start, next word, or retry).
    assign w_inReqWait = (r_state == ID_REQ) || (r_state == ID_WAIT) ||
                         (r_state == TS_REQ) || (r_state == TS_WAIT);
    assign w_inWait    = (r_state == ID_WAIT) || (r_state == TS_WAIT);

    // Data arriving on the expiry edge is still accepted.
    assign w_dataWins  = w_inWait && avm_readdatavalid;
    assign w_timeout   = w_inReqWait && w_expired && !w_dataWins;
    assign w_canRetry  = (r_retryCount < RETRY_W'(MAX_RETRIES));

    assign w_wdClear   = (((r_state == IDLE) || (r_state == DONE)) && start) ||
                         (w_timeout && w_canRetry) ||
                         ((r_state == ID_WAIT) && avm_readdatavalid);

    sysid_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_wdClear),
        .i_enable  (w_inReqWait),
        .o_expired (w_expired)
    );

    // Sequencer with registered outputs. A timeout is handled ahead of the
    // per-state logic because it can strike in any of the four bus states;
    // a retry jumps straight back into ID_REQ with the read already raised.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_retryCount   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_code      <= FC_OK;
            avm_address    <= 1'b0;
            avm_read       <= 1'b0;
            id_word        <= '0;
            timestamp_word <= '0;
        end else if (w_timeout) begin
            if (w_canRetry) begin
                r_retryCount <= r_retryCount + RETRY_W'(1);
                avm_read     <= 1'b1;
                avm_address  <= 1'b0;
                r_state      <= ID_REQ;
            end else begin
                avm_read     <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
                pass         <= 1'b0;
                fail_code    <= FC_TIMEOUT;
                r_state      <= DONE;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail_code    <= FC_OK;
                        busy         <= 1'b1;
                        r_retryCount <= '0;
                        avm_read     <= 1'b1;
                        avm_address  <= 1'b0;
                        r_state      <= ID_REQ;
                    end
                end
                ID_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        r_state  <= ID_WAIT;
                    end
                end
                ID_WAIT: begin
                    if (avm_readdatavalid) begin
                        id_word     <= avm_readdata;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        r_state     <= TS_REQ;
                    end
                end
                TS_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        r_state  <= TS_WAIT;
                    end
                end
                TS_WAIT: begin
                    if (avm_readdatavalid) begin
                        timestamp_word <= avm_readdata;
                        r_state        <= CHECK;
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (id_word != EXPECTED_ID) begin
                        pass      <= 1'b0;
                        fail_code <= FC_ID;
                    end else if (timestamp_word != EXPECTED_TIMESTAMP) begin
                        pass      <= 1'b0;
                        fail_code <= FC_TS;
                    end else begin
                        pass      <= 1'b1;
                        fail_code <= FC_OK;
                    end
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_sysid_checker
// Directed bench for sysid_checker. Two instances share every input: "f"
// uses a short watchdog (8 cycles, 2 retries) for the timeout scenario, "l"
// keeps the defaults so a long slave stall does not time out. Inputs change
// 1 time unit after a rising edge and outputs are examined at the same point.
// ---------------------------------------------------------------------------
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1346454016;

    logic        clock;
    logic        reset;
    logic        start;
    logic        avmWaitrequest;
    logic        avmReaddatavalid;
    logic [31:0] avmReaddata;

    logic        fBusy, fDone, fPass, fAddr, fRead;
    logic [1:0]  fFailCode;
    logic [31:0] fIdWord, fTsWord;

    logic        lBusy, lDone, lPass, lAddr, lRead;
    logic [1:0]  lFailCode;
    logic [31:0] lIdWord, lTsWord;

    int checks;
    int failures;
    int idReqCount;
    int doneEdge;

    sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .busy              (fBusy),
        .done              (fDone),
        .pass              (fPass),
        .fail_code         (fFailCode),
        .avm_address       (fAddr),
        .avm_read          (fRead),
        .avm_waitrequest   (avmWaitrequest),
        .avm_readdatavalid (avmReaddatavalid),
        .avm_readdata      (avmReaddata),
        .id_word           (fIdWord),
        .timestamp_word    (fTsWord)
    );

    sysid_checker dutLong (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .busy              (lBusy),
        .done              (lDone),
        .pass              (lPass),
        .fail_code         (lFailCode),
        .avm_address       (lAddr),
        .avm_read          (lRead),
        .avm_waitrequest   (avmWaitrequest),
        .avm_readdatavalid (avmReaddatavalid),
        .avm_readdata      (avmReaddata),
        .id_word           (lIdWord),
        .timestamp_word    (lTsWord)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Counts cycles in which the short-watchdog instance presents a word-0
    // read, i.e. how many ID_REQ attempts it has issued.
    always @(negedge clock) begin
        if (fRead && !fAddr) idReqCount++;
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] global time limit reached");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic wr, input logic rdv, input logic [31:0] data);
        start            = s;
        avmWaitrequest   = wr;
        avmReaddatavalid = rdv;
        avmReaddata      = data;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idReqCount = 0;
    endtask

    // Zero-wait slave, data one cycle after acceptance. Leaves the DUT just
    // after edge 4 (in CHECK); the caller's next tick is edge 5.
    task automatic runSequence(input logic [31:0] w0, input logic [31:0] w1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, w0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, w1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #3;
        checks++;
        if ({fBusy, fDone, fPass, fFailCode, fRead, fAddr} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl_f: got %b expected 0000000", {fBusy, fDone, fPass, fFailCode, fRead, fAddr});
        end
        checks++;
        if ({fIdWord, fTsWord} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_words_f: got %h expected 0", {fIdWord, fTsWord});
        end
        checks++;
        if ({lBusy, lDone, lPass, lFailCode, lRead, lAddr} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl_l: got %b expected 0000000", {lBusy, lDone, lPass, lFailCode, lRead, lAddr});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({fBusy, fDone, fRead} !== 3'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected 000", {fBusy, fDone, fRead});
        end
    endtask

    task automatic test_nominal();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({fBusy, fRead, fAddr} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL nom_id_req: busy/read/addr got %b expected 110", {fBusy, fRead, fAddr});
        end
        tick();
        checks++;
        if (fRead !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nom_id_wait_read: got %b expected 0", fRead);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, EXP_ID);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({fRead, fAddr} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL nom_ts_req: read/addr got %b expected 11", {fRead, fAddr});
        end
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, EXP_TS);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({fDone, fBusy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL nom_edge4: done/busy got %b expected 01", {fDone, fBusy});
        end
        tick();
        checks++;
        if ({fDone, fBusy, fPass, fFailCode} !== 5'b10100) begin
            failures++;
            $display("[TB] FAIL nom_edge5_f: done/busy/pass/code got %b expected 10100", {fDone, fBusy, fPass, fFailCode});
        end
        checks++;
        if (fIdWord !== EXP_ID || fTsWord !== EXP_TS) begin
            failures++;
            $display("[TB] FAIL nom_words_f: got %h %h expected %h %h", fIdWord, fTsWord, EXP_ID, EXP_TS);
        end
        checks++;
        if ({lDone, lBusy, lPass, lFailCode} !== 5'b10100) begin
            failures++;
            $display("[TB] FAIL nom_edge5_l: done/busy/pass/code got %b expected 10100", {lDone, lBusy, lPass, lFailCode});
        end
        checks++;
        if (lTsWord !== EXP_TS) begin
            failures++;
            $display("[TB] FAIL nom_ts_l: got %h expected %h", lTsWord, EXP_TS);
        end
    endtask

    task automatic test_id_mismatch();
        doReset();
        runSequence(32'h1, EXP_TS);
        tick();
        checks++;
        if ({fDone, fPass, fFailCode} !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL idmis_result: done/pass/code got %b expected 1001", {fDone, fPass, fFailCode});
        end
        checks++;
        if (fIdWord !== 32'h1) begin
            failures++;
            $display("[TB] FAIL idmis_word: got %h expected 00000001", fIdWord);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (idReqCount !== 1) begin
            failures++;
            $display("[TB] FAIL idmis_no_retry: ID requests got %0d expected 1", idReqCount);
        end
        checks++;
        if ({fDone, fBusy, fFailCode} !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL idmis_hold: done/busy/code got %b expected 1001", {fDone, fBusy, fFailCode});
        end
    endtask

    task automatic test_stall();
        int unstable;
        doReset();
        unstable = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, EXP_ID);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({lRead, lAddr} !== 2'b11) unstable++;
        end
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("[TB] FAIL stall_stable: cycles with read/addr != 11 got %0d expected 0", unstable);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({lRead, lBusy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_accept: read/busy got %b expected 01", {lRead, lBusy});
        end
        applyStimulus(1'b0, 1'b0, 1'b1, EXP_TS);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({lDone, lPass, lFailCode} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL stall_result: done/pass/code got %b expected 1100", {lDone, lPass, lFailCode});
        end
    endtask

    task automatic test_timeout_retry();
        doReset();
        doneEdge = -1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 40 && doneEdge < 0; k++) begin
            tick();
            if (fDone === 1'b1) doneEdge = k;
        end
        checks++;
        if (doneEdge < 27 || doneEdge > 28) begin
            failures++;
            $display("[TB] FAIL to_done_edge: got %0d expected 27..28 (-1 = never within 40)", doneEdge);
        end
        checks++;
        if ({fBusy, fPass, fFailCode} !== 4'b0011) begin
            failures++;
            $display("[TB] FAIL to_result: busy/pass/code got %b expected 0011", {fBusy, fPass, fFailCode});
        end
        checks++;
        if (idReqCount !== 3) begin
            failures++;
            $display("[TB] FAIL to_attempts: ID requests got %0d expected 3", idReqCount);
        end
        runSequence(EXP_ID, EXP_TS);
        checks++;
        if ({fDone, fBusy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL to_restart_clear: done/busy got %b expected 01", {fDone, fBusy});
        end
        tick();
        checks++;
        if ({fDone, fPass, fFailCode} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL to_recover: done/pass/code got %b expected 1100", {fDone, fPass, fFailCode});
        end
    endtask

    task automatic test_reset_mid_read();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checks++;
        if ({fRead, fAddr} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL rst_pre_req: read/addr got %b expected 11", {fRead, fAddr});
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({fRead, fBusy, fDone} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rst_async_req: read/busy/done got %b expected 000", {fRead, fBusy, fDone});
        end
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({fRead, fBusy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL rst_pre_wait: read/busy got %b expected 01", {fRead, fBusy});
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({fRead, fBusy, fDone, fIdWord} !== 35'h0) begin
            failures++;
            $display("[TB] FAIL rst_async_wait: read/busy/done/id got %h expected 0", {fRead, fBusy, fDone, fIdWord});
        end
        @(negedge clock);
        reset = 1'b0;
        runSequence(EXP_ID, EXP_TS);
        tick();
        checks++;
        if ({fDone, fPass, fFailCode, lDone, lPass} !== 6'b110011) begin
            failures++;
            $display("[TB] FAIL rst_clean_run: f done/pass/code l done/pass got %b expected 110011", {fDone, fPass, fFailCode, lDone, lPass});
        end
    endtask

    task automatic test_start_busy_stray();
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({fIdWord, fTsWord} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL stray_idle_words: got %h expected 0", {fIdWord, fTsWord});
        end
        checks++;
        if ({fBusy, fDone, fRead} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL stray_idle_state: busy/done/read got %b expected 000", {fBusy, fDone, fRead});
        end
        idReqCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, EXP_ID);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, EXP_TS);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({fDone, fPass, fFailCode} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL busy_start_ignored: done/pass/code got %b expected 1100", {fDone, fPass, fFailCode});
        end
        checks++;
        if (idReqCount !== 1) begin
            failures++;
            $display("[TB] FAIL busy_start_requests: got %0d expected 1", idReqCount);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (fIdWord !== EXP_ID || fTsWord !== EXP_TS) begin
            failures++;
            $display("[TB] FAIL stray_done_words: got %h %h expected %h %h", fIdWord, fTsWord, EXP_ID, EXP_TS);
        end
        checks++;
        if ({fDone, fPass, fBusy} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL stray_done_state: done/pass/busy got %b expected 110", {fDone, fPass, fBusy});
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        idReqCount = 0;
        doneEdge   = -1;
        reset      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        test_reset();
        test_nominal();
        test_id_mismatch();
        test_stall();
        test_timeout_retry();
        test_reset_mid_read();
        test_start_busy_stray();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
